// File: rtl/conv_pkg.sv
// Shared defaults and types for the conv-core post-processing blocks.
package conv_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int FMAP_W_DEF = 8;
  localparam int FMAP_H_DEF = 8;

  typedef logic signed [DATA_W_DEF-1:0] data_t;

  // Pool FSM tracks which row of a 2x2 window is streaming in.
  typedef enum logic {
    ST_TOP = 1'b0,
    ST_BOT = 1'b1
  } pool_state_e;
endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding per-window max of the top row; one write, one async read.
// Not reset: every entry is written in the top row before the bottom row reads it.
module pool_line_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/conv_pool.sv
// 2x2 max pool (stride 2) with optional ReLU on a raster-ordered conv result stream.
module conv_pool import conv_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FMAP_W = FMAP_W_DEF,
  parameter int FMAP_H = FMAP_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              relu_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_done
);
  localparam int COL_W = (FMAP_W > 2) ? $clog2(FMAP_W) : 1;
  localparam int ROW_W = (FMAP_H > 2) ? $clog2(FMAP_H) : 1;
  localparam int DEPTH = FMAP_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (FMAP_W % 2 != 0) begin : g_chk_w
    $error("conv_pool: FMAP_W must be even");
  end
  if (FMAP_H % 2 != 0) begin : g_chk_h
    $error("conv_pool: FMAP_H must be even");
  end

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  pool_state_e              state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic signed [DATA_W-1:0] pair_q, pair_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     frame_done_q, frame_done_d;

  logic                     lb_we;
  logic [AW-1:0]            lb_addr;
  logic signed [DATA_W-1:0] lb_wdata, lb_rdata, res, din;
  logic                     col_last, row_last;

  assign din      = $signed(in_data);
  assign lb_addr  = AW'(col_q >> 1);
  assign col_last = (col_q == COL_W'(FMAP_W - 1));
  assign row_last = (row_q == ROW_W'(FMAP_H - 1));

  pool_line_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (lb_wdata),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // Counters, FSM, compare tree and output staging; everything holds without in_valid.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    lb_wdata     = smax(pair_q, din);
    res          = smax(lb_wdata, lb_rdata);
    if (in_valid) begin
      if (!col_q[0]) begin
        pair_d = din;
      end else if (state_q == ST_TOP) begin
        lb_we = 1'b1;
      end else begin
        out_data_d   = (relu_en && res < 0) ? '0 : res;
        out_valid_d  = 1'b1;
        frame_done_d = row_last && col_last;
      end
      if (col_last) begin
        col_d   = '0;
        row_d   = row_last ? '0 : row_q + 1'b1;
        state_d = (state_q == ST_TOP) ? ST_BOT : ST_TOP;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_TOP;
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_pool.sv
// Scoreboard bench for conv_pool on a 4x4 feature map.
module tb_conv_pool;
  import conv_pkg::*;
  localparam int DW = 32, FW = 4, FH = 4, N = FW * FH;

  typedef logic signed [DW-1:0] frame_t [N];
  typedef struct {
    logic signed [DW-1:0] data;
    logic                 fd;
    int                   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, relu_en;
  logic [DW-1:0] in_data, out_data;
  logic out_valid, frame_done;

  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0, fd_cnt = 0;
  logic signed [DW-1:0] held = '0;

  conv_pool #(.DATA_W(DW), .FMAP_W(FW), .FMAP_H(FH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .relu_en(relu_en),
    .out_data(out_data), .out_valid(out_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on out_valid, checks hold behaviour otherwise.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      held = '0;
      tests++;
      assert (out_valid === 1'b0 && frame_done === 1'b0 && out_data === '0)
        else begin fails++; $error("FAIL reset_out: v=%b fd=%b d=%0d, want 0/0/0", out_valid, frame_done, $signed(out_data)); end
    end else if (out_valid === 1'b1) begin
      tests++;
      assert (sb.size() > 0)
        else begin fails++; $error("FAIL stray_valid: out_valid=1 d=%0d at cyc %0d, want no output", $signed(out_data), cyc); end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        tests++;
        assert (out_data === e.data && frame_done === e.fd && cyc == e.cyc)
          else begin fails++; $error("FAIL pool_out: d=%0d fd=%b cyc=%0d, want d=%0d fd=%b cyc=%0d", $signed(out_data), frame_done, cyc, e.data, e.fd, e.cyc); end
        held = e.data;
      end
      if (frame_done === 1'b1) fd_cnt++;
    end else begin
      tests++;
      assert (out_valid === 1'b0 && frame_done === 1'b0 && out_data === held)
        else begin fails++; $error("FAIL idle_hold: v=%b fd=%b d=%0d, want 0/0/%0d", out_valid, frame_done, $signed(out_data), held); end
    end
  end

  function automatic logic signed [DW-1:0] max4(input logic signed [DW-1:0] a, b, c, d);
    logic signed [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Drive the first n samples of frame f, gap idle cycles after each; expected
  // pooled value is derived directly from the 2x2 window in the frame array.
  task automatic send(input frame_t f, input logic relu, input int gap, input int n);
    for (int i = 0; i < n; i++) begin
      int r, c;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = f[i];
      relu_en  = relu;
      r = i / FW;
      c = i % FW;
      if (r % 2 == 1 && c % 2 == 1) begin
        exp_t e;
        e.data = max4(f[i-FW-1], f[i-FW], f[i-1], f[i]);
        if (relu && e.data < 0) e.data = '0;
        e.fd  = (i == N - 1);
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        relu_en  = ~relu;
      end
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    tests++;
    assert (sb.size() == 0)
      else begin fails++; $error("FAIL %s_drain: %0d outputs missing, want 0", tag, sb.size()); end
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    frame_t f_inc, f_neg, f_ext, f_rnd;
    int fd0;
    for (int i = 0; i < N; i++) begin
      f_inc[i] = i;
      f_neg[i] = i - 16;
      f_ext[i] = i;
      f_rnd[i] = $urandom;
    end
    f_ext[0] = 32'sh7FFFFFFF;
    f_ext[1] = 32'sh80000000;
    f_ext[4] = -1;
    f_ext[5] = 0;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; relu_en = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    tests++;
    assert (out_data === '0 && out_valid === 1'b0 && frame_done === 1'b0)
      else begin fails++; $error("FAIL reset_state: d=%0d v=%b fd=%b, want 0/0/0", $signed(out_data), out_valid, frame_done); end
    rst = 1'b0;

    // Ascending frame, full rate: 5,7,13,15.
    fd0 = fd_cnt;
    send(f_inc, 1'b0, 0, N);
    drain("inc");
    tests++;
    assert (fd_cnt - fd0 == 1)
      else begin fails++; $error("FAIL inc_fd_count: %0d, want 1", fd_cnt - fd0); end

    // All negative, with and without ReLU.
    send(f_neg, 1'b0, 0, N);
    drain("neg");
    send(f_neg, 1'b1, 0, N);
    drain("neg_relu");

    // in_valid toggling 1-0-0.
    send(f_inc, 1'b0, 2, N);
    drain("gaps");

    // Signed extremes in the first window.
    send(f_ext, 1'b0, 0, N);
    drain("ext");

    // Reset mid-frame, then a clean frame.
    send(f_inc, 1'b0, 0, 6);
    drain("partial");
    do_reset();
    send(f_inc, 1'b0, 0, N);
    drain("after_rst");

    // Two frames back to back.
    fd0 = fd_cnt;
    send(f_rnd, 1'b0, 0, N);
    send(f_inc, 1'b0, 0, N);
    drain("b2b");
    tests++;
    assert (fd_cnt - fd0 == 2)
      else begin fails++; $error("FAIL b2b_fd_count: %0d, want 2", fd_cnt - fd0); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
